i2s_transmitter: RTL
====================

# i2s_transmitter

Serialises stereo PCM samples onto an I2S data line for an external DAC (CS4344-class), generating the bit clock and word select from the main clock. It is the playback-side counterpart of the I2S capture path and uses the same clock ratios. Sample producers, such as the mixer or effects chain, hand it one stereo pair per frame through a valid/ready handshake into a single-entry holding register. If no pair is waiting when a frame starts, the block transmits silence and flags an underrun.

## Interface
- WIDTH, 16: sample width in bits. Must satisfy 2 ≤ WIDTH ≤ SERIAL_TO_LEFT_RIGHT/2 − 1.
- MAIN_TO_SERIAL, 24: sclk period in mclk cycles. Even, ≥ 4.
- SERIAL_TO_LEFT_RIGHT, 64: ws (frame) period in sclk cycles. Even.
- mclk  in  1  main clock; every register is clocked on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_data_l  in  WIDTH  left sample, two's complement, MSB first on the wire.
- tx_data_r  in  WIDTH  right sample.
- tx_valid  in  1  the stereo pair on tx_data_l/r is valid.
- tx_ready  out  1  the holding register is empty; the pair is accepted when tx_valid && tx_ready.
- sd_tx  out  1  serial data to the DAC.
- sclk  out  1  serial bit clock.
- ws  out  1  word select: 0 = left, 1 = right.
- frame_start  out  1  one-cycle pulse when a new frame is loaded.
- underrun  out  1  one-cycle pulse when a frame is loaded while the holding register is empty.

## Operation
- Reset values (asserted asynchronously, released synchronously on mclk):
  - Counters, shift registers and holding register: 0.
  - hold_full: 0, so tx_ready = 1.
  - sclk, ws, sd_tx, frame_start, underrun: 0.
- Clock divider:
  - div_cnt counts 0..MAIN_TO_SERIAL/2−1.
  - At the terminal count, div_cnt wraps to 0 and sclk toggles.
- Slot counter:
  - bit_cnt counts 0..SERIAL_TO_LEFT_RIGHT−1.
  - It advances only on mclk edges where sclk goes 1→0 (falling edge), wrapping to 0.
  - A slot spans one sclk low half followed by one sclk high half.
- Word select: ws = 1 exactly while bit_cnt ≥ SERIAL_TO_LEFT_RIGHT/2. It is registered and changes on the same mclk edge as the sclk falling edge.
- Data is standard I2S, one-bit delayed. With H = SERIAL_TO_LEFT_RIGHT/2:
  - Slot k (1 ≤ k ≤ WIDTH) carries left bit WIDTH−k.
  - Slot H+k carries right bit WIDTH−k.
  - All other slots (0, WIDTH+1..H, H+WIDTH+1..end) carry 0.
- sd_tx updates only on sclk falling edges. It is stable across the following rising edge, where the DAC samples.
- Frame load happens on the falling edge where bit_cnt wraps from SERIAL_TO_LEFT_RIGHT−1 to 0:
  - If hold_full: the shift registers take the holding register, hold_full clears, and frame_start pulses.
  - If not hold_full: the shift registers take 0, frame_start pulses and underrun pulses.
- Handshake:
  - tx_ready = !hold_full, driven combinationally from the register.
  - An accept sets hold_full and captures both samples together.
  - The producer may present a pair at any time; it waits at most one frame.
- Accept on the load edge: the load sees the pre-edge hold_full = 0, so it underruns and sends zeros. The newly accepted pair is sent in the next frame.
- tx_valid without tx_ready leaves the holding register unchanged.
- Reset mid-frame aborts the frame immediately: all outputs go to their reset values, and the pending pair is discarded.

## Timing
- Clock edges are counted as mclk rising edges after rst_n deasserts; edge 1 is the first.
- sclk rises at edges 12, 36, … and falls at 24, 48, … (default parameters).
- Frame length is MAIN_TO_SERIAL × SERIAL_TO_LEFT_RIGHT = 1536 mclk. The first frame load is at edge 1536, so the first frame after reset is always silent.
- Latency from accept to MSB on sd_tx: up to one frame (until the next load), plus 1 sclk period.
- Outputs are registered; frame_start and underrun assert on the load edge for exactly 1 cycle.

## Test plan
- Reset behaviour: hold rst_n low for 5 cycles, then release with tx_valid = 0.
  - sclk period is 24 mclk and ws period is 1536 mclk.
  - sd_tx stays 0 throughout.
  - underrun pulses at edge 1536 and every 1536 cycles after.
- Bit order: accept L = 16'hA5C3, R = 16'h0001 before edge 1536.
  - Sampling sd_tx on sclk rising edges of frame 2 gives slot 0 = 0 and slots 1..16 = 1010_0101_1100_0011.
  - Slots 17..31 are 0; slots 33..48 are 0x0001 MSB-first; underrun stays 0.
- Back-pressure: hold tx_valid = 1 continuously with incrementing pairs.
  - tx_ready is high for exactly 1 cycle per frame.
  - Each accepted pair appears in order in consecutive frames, with no underrun.
- Simultaneous accept and load: assert tx_valid only on the load edge while the holding register is empty.
  - underrun pulses and that frame transmits zeros.
  - The pair appears in the following frame.
- Asynchronous reset mid-frame: pull rst_n low at bit_cnt = 10 without an mclk edge.
  - sclk, ws, sd_tx and the pulse outputs go to 0 at once and tx_ready goes to 1.
  - After release, the timing restarts exactly as in the reset-behaviour scenario.
- Loopback: connect to the I2S receiver (mclk shared, sclk, ws and sd_tx wired to it).
  - After two frames, receiver rx_data_l and rx_data_r equal the transmitted 16'h7FFF and 16'h8000.

Source files
------------

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//
// Serialises one stereo PCM pair per frame onto a standard (one-bit delayed) I2S line and
// generates the bit clock and word select from the main clock. Producers hand over a pair
// through a valid/ready handshake into a single-entry holding register. A frame that starts
// with the holding register empty is sent as silence and flagged with an underrun pulse.
//
// Parameters:
//   WIDTH                 sample width in bits, 2 <= WIDTH <= SERIAL_TO_LEFT_RIGHT/2 - 1
//   MAIN_TO_SERIAL        sclk period in mclk cycles (even, >= 4)
//   SERIAL_TO_LEFT_RIGHT  frame (ws) period in sclk cycles (even)
//
// Ports:
//   mclk         in   main clock, all registers on its rising edge
//   rst_n        in   asynchronous active-low reset
//   tx_data_l    in   left sample, two's complement, MSB first on the wire
//   tx_data_r    in   right sample
//   tx_valid     in   pair on tx_data_l/r is valid
//   tx_ready     out  holding register empty; pair accepted on tx_valid && tx_ready
//   sd_tx        out  serial data to the DAC
//   sclk         out  serial bit clock
//   ws           out  word select, 0 = left, 1 = right
//   frame_start  out  one-cycle pulse when a new frame is loaded
//   underrun     out  one-cycle pulse when a frame is loaded with the holding register empty

module i2s_transmitter #(
  parameter int unsigned WIDTH                = 16,
  parameter int unsigned MAIN_TO_SERIAL       = 24,
  parameter int unsigned SERIAL_TO_LEFT_RIGHT = 64
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data_l,
  input  logic [WIDTH-1:0] tx_data_r,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sd_tx,
  output logic             sclk,
  output logic             ws,
  output logic             frame_start,
  output logic             underrun
);

  localparam int unsigned HalfDiv = MAIN_TO_SERIAL / 2;
  localparam int unsigned DivW    = (HalfDiv > 1) ? $clog2(HalfDiv) : 1;
  localparam int unsigned SlotW   = $clog2(SERIAL_TO_LEFT_RIGHT);

  localparam logic [DivW-1:0]  DivLast      = DivW'(HalfDiv - 1);
  localparam logic [SlotW-1:0] SlotLast     = SlotW'(SERIAL_TO_LEFT_RIGHT - 1);
  localparam logic [SlotW-1:0] SlotHalf     = SlotW'(SERIAL_TO_LEFT_RIGHT / 2);
  localparam logic [SlotW-1:0] SlotLeftEnd  = SlotW'(WIDTH);
  localparam logic [SlotW-1:0] SlotRightEnd = SlotW'(SERIAL_TO_LEFT_RIGHT / 2 + WIDTH);

  // Clock divider and slot counter
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic [SlotW-1:0] bit_cnt_q, bit_cnt_d;
  logic             ws_q, ws_d;

  // Serial datapath
  logic             sd_q, sd_d;
  logic [WIDTH-1:0] sh_l_q, sh_l_d;
  logic [WIDTH-1:0] sh_r_q, sh_r_d;

  // Single-entry holding register
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;

  // Registered status pulses
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;

  logic div_last;
  logic sclk_fall;
  logic slot_last;
  logic frame_load;
  logic accept;

  assign div_last   = (div_cnt_q == DivLast);
  // The divider toggles sclk at its terminal count, so a toggle from 1 is a falling edge.
  assign sclk_fall  = div_last && sclk_q;
  assign slot_last  = (bit_cnt_q == SlotLast);
  assign frame_load = sclk_fall && slot_last;
  assign accept     = tx_valid && !hold_full_q;

  always_comb begin
    div_cnt_d     = div_cnt_q;
    sclk_d        = sclk_q;
    bit_cnt_d     = bit_cnt_q;
    ws_d          = ws_q;
    sd_d          = sd_q;
    sh_l_d        = sh_l_q;
    sh_r_d        = sh_r_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (div_last) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end

    // Everything on the wire moves on the sclk falling edge so the DAC sees stable data
    // on the following rising edge.
    if (sclk_fall) begin
      bit_cnt_d = slot_last ? '0 : bit_cnt_q + SlotW'(1);
      ws_d      = (bit_cnt_d >= SlotHalf);
      sd_d      = 1'b0;

      if (frame_load) begin
        // Slot 0 of each half is the I2S delay bit, so the new frame starts with a 0.
        sh_l_d        = hold_full_q ? hold_l_q : '0;
        sh_r_d        = hold_full_q ? hold_r_q : '0;
        frame_start_d = 1'b1;
        underrun_d    = ~hold_full_q;
      end else if (bit_cnt_d <= SlotLeftEnd) begin
        sd_d   = sh_l_q[WIDTH-1];
        sh_l_d = {sh_l_q[WIDTH-2:0], 1'b0};
      end else if ((bit_cnt_d > SlotHalf) && (bit_cnt_d <= SlotRightEnd)) begin
        sd_d   = sh_r_q[WIDTH-1];
        sh_r_d = {sh_r_q[WIDTH-2:0], 1'b0};
      end
    end

    // The load consumes the pre-edge holding state; an accept on the load edge only lands
    // in the register and waits for the next frame. Both cannot coincide with a full
    // register because tx_ready is low then.
    if (frame_load && hold_full_q) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_l_d    = tx_data_l;
      hold_r_d    = tx_data_r;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      sclk_q        <= 1'b0;
      bit_cnt_q     <= '0;
      ws_q          <= 1'b0;
      sd_q          <= 1'b0;
      sh_l_q        <= '0;
      sh_r_q        <= '0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      sclk_q        <= sclk_d;
      bit_cnt_q     <= bit_cnt_d;
      ws_q          <= ws_d;
      sd_q          <= sd_d;
      sh_l_q        <= sh_l_d;
      sh_r_q        <= sh_r_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign sd_tx       = sd_q;
  assign sclk        = sclk_q;
  assign ws          = ws_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule
